esm_select_engine: RTL and testbench
====================================

// Module: esm_select_engine
// PURPOSE
//  Next-generation ESM selection core: picks one free buffer entry at random from a
//  parametrised candidate set and hands it to the consumer over a valid/ready handshake.
//  Tracks entries it has issued as busy until they are released.
//  Sits between the buffer ready-status vector and the consumer that allocates buffer slots.
// PARAMETERS
//  BS    16            buffer entries; power of two, 2..64; IW = $clog2(BS)
//  SEED  32'h1         LFSR reset value; must be nonzero (elaboration error otherwise)
//  TAPS  32'h80200003  Galois LFSR feedback mask (x^32+x^22+x^2+x+1)
// PORTS
//  clk            in   1    clock, rising edge
//  rst            in   1    async reset, active-high
//  start          in   1    request one selection; sampled only in IDLE
//  ready_index    in   BS   per-entry ready status from buffer
//  release_valid  in   1    free a previously granted entry
//  release_index  in   IW   entry to free
//  grant_valid    out  1    grant_index valid; held until grant_ready
//  grant_ready    in   1    consumer accepts grant
//  grant_index    out  IW   selected entry
//  no_cand        out  1    1-cycle pulse: selection found no candidate
//  busy_mask      out  BS   entries granted and not yet released
//  idle           out  1    FSM in IDLE
// BEHAVIOUR
//  Reset (async): FSM=IDLE, lfsr=SEED, grant_valid=0, grant_index=0, no_cand=0,
//   busy_mask=0, cand=0, idle=1.
//  LFSR: 32-bit Galois shift right every cycle:
//   lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0). Free-running, never zero.
//  cand register: cand <= ready_index & ~busy_mask every cycle (1-cycle delay).
//  FSM:
//   IDLE : start=1 -> off <= lfsr[IW-1:0], go SCAN; else stay.
//   SCAN : circular search of cand from bit off upward, wrapping at BS-1 -> 0;
//          first set bit found -> grant_index <= it, grant_valid <= 1, go GRANT;
//          cand==0 -> no_cand pulses 1 cycle, go IDLE.
//   GRANT: grant_valid=1 and grant_index stable until grant_ready=1; on accept
//          busy_mask[grant_index] <= 1, grant_valid <= 0, go IDLE.
//  Latency: start -> grant_valid = 2 cycles (IDLE sample, SCAN register).
//  Back-to-back: next start accepted in the cycle after handshake (in IDLE).
//  Release: busy_mask[release_index] <= 0 on release_valid in any state.
//   Release of a non-busy index: no-op.
//   Release and grant accept on the same index in the same cycle: set wins (bit = 1).
//  start outside IDLE: ignored, not queued.
//  ready_index changes during GRANT: no effect on the pending grant.
//  grant_ready without grant_valid: ignored.
//  Async reset mid-GRANT: grant dropped immediately; busy_mask cleared.
// CONFIGURATION
//  ESM_STATS_EN defined: adds ports grant_count out 16 and miss_count out 16.
//   grant_count increments on each accepted handshake; miss_count on each no_cand.
//   Both saturate at 16'hFFFF; both reset to 0.
//  ESM_STATS_EN undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs at reset values same cycle;
//    lfsr==SEED after release.
//  2 Single candidate: ready=16'h0100, start -> grant_valid after 2 cycles,
//    grant_index=8 regardless of off; busy_mask=16'h0100 after accept.
//  3 Random spread: ready=16'hFFFF, 16 start/accept/release loops ->
//    each grant_index == off (captured lfsr[3:0]), matched against ref LFSR model.
//  4 Back-pressure: hold grant_ready=0 for 10 cycles, toggle ready_index ->
//    grant_valid and grant_index stable; accept on cycle 11.
//  5 Exhaustion: grant all 16 without release, start again -> no_cand 1-cycle pulse,
//    idle=1; release index 3, start -> grant_index=3.
//  6 Collision/stats: same-cycle release+accept on index 5 -> busy_mask[5]=1;
//    with ESM_STATS_EN, 3 grants + 1 miss -> grant_count=3, miss_count=1.

Source files
------------

// File: rtl/esm_grant_if.sv
// Grant handshake bundle between the ESM selection engine and the slot consumer.
// The engine is the master: it drives valid/index and samples ready.
interface esm_grant_if #(
    parameter int BS = 16
);
    localparam int IW = $clog2(BS);

    logic          grant_valid;
    logic          grant_ready;
    logic [IW-1:0] grant_index;

    modport master (
        output grant_valid,
        output grant_index,
        input  grant_ready
    );

    modport slave (
        input  grant_valid,
        input  grant_index,
        output grant_ready
    );
endinterface

// File: rtl/esm_select_engine.sv
// ESM selection core: random-offset circular pick of a free buffer entry with busy tracking.
// Optional grant/miss statistics counters are built when ESM_STATS_EN is defined.
module esm_select_engine #(
    parameter int          BS   = 16,
    parameter logic [31:0] SEED = 32'h1,
    parameter logic [31:0] TAPS = 32'h80200003,
    localparam int         IW   = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BS-1:0] ready_index,
    input  logic          release_valid,
    input  logic [IW-1:0] release_index,
    esm_grant_if.master   gnt,
    output logic          no_cand,
    output logic [BS-1:0] busy_mask,
`ifdef ESM_STATS_EN
    output logic [15:0]   grant_count,
    output logic [15:0]   miss_count,
`endif
    output logic          idle
);

    if (SEED == 32'h0) begin : g_bad_seed
        $error("esm_select_engine: SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [BS-1:0] cand_q, cand_d;
    logic [BS-1:0] busy_q, busy_d;
    logic [IW-1:0] off_q, off_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic          gvld_q, gvld_d;
    logic          nc_q, nc_d;
    logic          idle_q, idle_d;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] idx;
    logic          accept;

    // Circular search starting at the random offset; IW-bit add wraps naturally.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int i = 0; i < BS; i++) begin
            idx = off_q + IW'(i);
            if (!hit && cand_q[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign accept = (state_q == GRANT) && gnt.grant_ready;

    always_comb begin
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
        cand_d  = ready_index & ~busy_q;
        state_d = state_q;
        off_d   = off_q;
        gidx_d  = gidx_q;
        gvld_d  = gvld_q;
        nc_d    = 1'b0;
        busy_d  = busy_q;
        // Set after clear so a same-cycle accept of a released index keeps it busy.
        if (release_valid) busy_d[release_index] = 1'b0;
        if (accept)        busy_d[gidx_q]        = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    off_d   = lfsr_q[IW-1:0];
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    gidx_d  = hit_idx;
                    gvld_d  = 1'b1;
                    state_d = GRANT;
                end else begin
                    nc_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (gnt.grant_ready) begin
                    gvld_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                gvld_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
        idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cand_q  <= '0;
            busy_q  <= '0;
            off_q   <= '0;
            gidx_q  <= '0;
            gvld_q  <= 1'b0;
            nc_q    <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cand_q  <= cand_d;
            busy_q  <= busy_d;
            off_q   <= off_d;
            gidx_q  <= gidx_d;
            gvld_q  <= gvld_d;
            nc_q    <= nc_d;
            idle_q  <= idle_d;
        end
    end

    assign gnt.grant_valid = gvld_q;
    assign gnt.grant_index = gidx_q;
    assign no_cand         = nc_q;
    assign busy_mask       = busy_q;
    assign idle            = idle_q;

`ifdef ESM_STATS_EN
    logic [15:0] gcnt_q, gcnt_d;
    logic [15:0] mcnt_q, mcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        mcnt_d = mcnt_q;
        if (accept && gcnt_q != 16'hFFFF) gcnt_d = gcnt_q + 16'd1;
        if (nc_d && mcnt_q != 16'hFFFF)   mcnt_d = mcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign grant_count = gcnt_q;
    assign miss_count  = mcnt_q;
`endif

endmodule

// File: tb/tb_esm_select_engine.sv
// Directed self-checking bench for esm_select_engine (BS=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_esm_select_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ready_index;
    logic        release_valid;
    logic [3:0]  release_index;
    logic        no_cand;
    logic [15:0] busy_mask;
    logic        idle;
`ifdef ESM_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    esm_grant_if #(.BS(16)) gif ();

    esm_select_engine #(.BS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready_index  (ready_index),
        .release_valid(release_valid),
        .release_index(release_index),
        .gnt          (gif.master),
        .no_cand      (no_cand),
        .busy_mask    (busy_mask),
`ifdef ESM_STATS_EN
        .grant_count  (grant_count),
        .miss_count   (miss_count),
`endif
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Independent reference LFSR (x^32+x^22+x^2+x+1, seed 1).
    logic [31:0] m;
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 32'h1;
        else     m <= (m >> 1) ^ (m[0] ? 32'h80200003 : 32'h0);
    end

    function automatic logic [3:0] pick(input logic [15:0] c, input logic [3:0] off);
        logic [3:0] k;
        pick = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            k = off + 4'(i);
            if (c[k]) pick = k;
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns one falling edge after the start edge (engine in SCAN).
    task automatic go(output logic [3:0] off);
        start = 1'b1;
        off   = m[3:0];
        tick();
        start = 1'b0;
    endtask

    task automatic accept();
        gif.grant_ready = 1'b1;
        tick();
        gif.grant_ready = 1'b0;
    endtask

    task automatic rel(input logic [3:0] i);
        release_valid = 1'b1;
        release_index = i;
        tick();
        release_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] off;
        #1;
        checks++;
        if ({gif.grant_valid, gif.grant_index, no_cand, busy_mask, idle} !== {1'b0, 4'd0, 1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_init: got gv=%b gi=%0d nc=%b busy=%h idle=%b", gif.grant_valid, gif.grant_index, no_cand, busy_mask, idle);
        end
        tick();
        ready_index = 16'hFFFF;
        rst = 1'b0;
        go(off);
        tick();
        checks++;
        if (gif.grant_valid !== 1'b1 || gif.grant_index !== 4'd1) begin
            errors++;
            $display("FAIL reset_seed: got gv=%b gi=%0d want gv=1 gi=1", gif.grant_valid, gif.grant_index);
        end
        accept();
        checks++;
        if (busy_mask !== 16'h0002) begin
            errors++;
            $display("FAIL reset_busy_pre: got %h want 0002", busy_mask);
        end
        go(off);
        tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({gif.grant_valid, gif.grant_index, no_cand, busy_mask, idle} !== {1'b0, 4'd0, 1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_midgrant: got gv=%b gi=%0d nc=%b busy=%h idle=%b", gif.grant_valid, gif.grant_index, no_cand, busy_mask, idle);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] off;
        ready_index = 16'h0100;
        go(off);
        checks++;
        if (gif.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got gv=%b after 1 cycle want 0", gif.grant_valid);
        end
        tick();
        checks++;
        if (gif.grant_valid !== 1'b1 || gif.grant_index !== 4'd8) begin
            errors++;
            $display("FAIL single_grant: got gv=%b gi=%0d want gv=1 gi=8 (off=%0d)", gif.grant_valid, gif.grant_index, off);
        end
        accept();
        checks++;
        if (busy_mask !== 16'h0100 || gif.grant_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got busy=%h gv=%b idle=%b want 0100 0 1", busy_mask, gif.grant_valid, idle);
        end
        rel(4'd8);
        checks++;
        if (busy_mask !== 16'h0) begin
            errors++;
            $display("FAIL single_release: got busy=%h want 0000", busy_mask);
        end
    endtask

    task automatic test_spread();
        logic [3:0] off;
        ready_index = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            go(off);
            tick();
            checks++;
            if (gif.grant_valid !== 1'b1 || gif.grant_index !== off) begin
                errors++;
                $display("FAIL spread_%0d: got gv=%b gi=%0d want gv=1 gi=%0d", k, gif.grant_valid, gif.grant_index, off);
            end
            accept();
            rel(gif.grant_index);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] off;
        ready_index = 16'hFFFF;
        go(off);
        tick();
        for (int k = 0; k < 10; k++) begin
            ready_index = k[0] ? 16'h0000 : 16'h00F0;
            tick();
            checks++;
            if (gif.grant_valid !== 1'b1 || gif.grant_index !== off) begin
                errors++;
                $display("FAIL backpressure_%0d: got gv=%b gi=%0d want gv=1 gi=%0d", k, gif.grant_valid, gif.grant_index, off);
            end
        end
        accept();
        checks++;
        if (gif.grant_valid !== 1'b0 || busy_mask !== (16'h1 << off)) begin
            errors++;
            $display("FAIL backpressure_accept: got gv=%b busy=%h want 0 %h", gif.grant_valid, busy_mask, 16'h1 << off);
        end
        rel(off);
        ready_index = 16'hFFFF;
    endtask

    task automatic test_exhaust();
        logic [3:0]  off;
        logic [3:0]  e;
        logic [15:0] bm = 16'h0;
        ready_index = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            go(off);
            tick();
            e = pick(~bm, off);
            checks++;
            if (gif.grant_valid !== 1'b1 || gif.grant_index !== e) begin
                errors++;
                $display("FAIL exhaust_grant_%0d: got gv=%b gi=%0d want gv=1 gi=%0d", k, gif.grant_valid, gif.grant_index, e);
            end
            accept();
            bm[e] = 1'b1;
        end
        checks++;
        if (busy_mask !== 16'hFFFF) begin
            errors++;
            $display("FAIL exhaust_full: got busy=%h want ffff", busy_mask);
        end
        go(off);
        tick();
        checks++;
        if (no_cand !== 1'b1 || idle !== 1'b1 || gif.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_nocand: got nc=%b idle=%b gv=%b want 1 1 0", no_cand, idle, gif.grant_valid);
        end
        tick();
        checks++;
        if (no_cand !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_pulse: got nc=%b want 0", no_cand);
        end
        rel(4'd3);
        tick();
        go(off);
        tick();
        checks++;
        if (gif.grant_valid !== 1'b1 || gif.grant_index !== 4'd3) begin
            errors++;
            $display("FAIL exhaust_regrant: got gv=%b gi=%0d want gv=1 gi=3", gif.grant_valid, gif.grant_index);
        end
        accept();
    endtask

    task automatic test_collision();
        logic [3:0] off;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_index = 16'h0020;
        go(off);
        tick();
        checks++;
        if (gif.grant_index !== 4'd5) begin
            errors++;
            $display("FAIL collision_grant: got gi=%0d want 5", gif.grant_index);
        end
        gif.grant_ready = 1'b1;
        release_valid   = 1'b1;
        release_index   = 4'd5;
        tick();
        gif.grant_ready = 1'b0;
        release_valid   = 1'b0;
        checks++;
        if (busy_mask !== 16'h0020) begin
            errors++;
            $display("FAIL collision_setwins: got busy=%h want 0020", busy_mask);
        end
        rel(4'd5);
        for (int k = 0; k < 2; k++) begin
            go(off);
            tick();
            accept();
            rel(4'd5);
        end
        ready_index = 16'h0;
        go(off);
        tick();
        tick();
`ifdef ESM_STATS_EN
        checks++;
        if (grant_count !== 16'd3 || miss_count !== 16'd1) begin
            errors++;
            $display("FAIL stats: got grants=%0d misses=%0d want 3 1", grant_count, miss_count);
        end
`endif
        checks++;
        if (busy_mask !== 16'h0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL collision_end: got busy=%h idle=%b want 0000 1", busy_mask, idle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        ready_index     = 16'h0;
        release_valid   = 1'b0;
        release_index   = 4'd0;
        gif.grant_ready = 1'b0;
        test_reset();
        test_single();
        test_spread();
        test_backpressure();
        test_exhaust();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
